ofdm_adc_capture: RTL and testbench

Avalon-MM slave component in the receiver Qsys system that samples the external 14-bit OFDM ADC bus and holds samples in a capture buffer. The HPS arms it over the lightweight bridge. It triggers on signal amplitude, captures a programmed number of samples, and the HPS reads them back word by word. This block is the consumer of the exported ofdmadccontrol_external_adc_data conduit.

---
 rtl/ofdm_adc_capture.sv | 238 +++++++++++++++++++++++
 tb/tb_ofdm_adc_capture.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ofdm_adc_capture.sv
// OFDM ADC capture buffer with an Avalon-MM CSR slave.
// Samples the 14-bit ADC conduit, arms on an amplitude trigger (or a forced
// start), captures LENGTH samples into an inferred RAM and lets the HPS pop
// them back one word per DATA read.

module ofdm_adc_capture #(
    parameter int unsigned DEPTH             = 1024,
    parameter bit          ADC_OFFSET_BINARY = 1'b1,
    parameter int unsigned TRIG_HOLD         = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] adc_data,
    input  logic [2:0]  avs_address,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic        irq
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    localparam logic [2:0] AddrCtrl   = 3'd0;
    localparam logic [2:0] AddrThresh = 3'd1;
    localparam logic [2:0] AddrLength = 3'd2;
    localparam logic [2:0] AddrStatus = 3'd3;
    localparam logic [2:0] AddrData   = 3'd4;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StArmed   = 2'd1,
        StCapture = 2'd2,
        StDone    = 2'd3
    } state_e;

    // Input pipeline
    logic [13:0] adc_q1, adc_q2;
    logic [13:0] s;
    logic [13:0] mag_full;
    logic [12:0] mag;
    logic        over_thresh;

    // Capture control state
    state_e         state_q;
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]  fill_q;
    logic [3:0]     trig_cnt_q;
    logic [3:0]     trig_cnt_inc;
    logic           triggered_q;
    logic           overflow_rd_q;

    // CSRs
    logic [12:0]    thresh_q;
    logic [LW-1:0]  length_q;
    logic [LW-1:0]  length_wr;
    logic           irq_en_q;
    logic           irq_q;

    // Read path
    logic [31:0]    csr_rdata_d, csr_rdata_q;
    logic           data_sel_q;
    logic [13:0]    ram_rdata_q;
    logic [13:0]    mem [DEPTH];

    // Decoded strobes
    logic ctrl_wr, ctrl_arm, ctrl_clear, ctrl_force;
    logic data_rd, pop, cap_wr;

    assign ctrl_wr    = avs_write && (avs_address == AddrCtrl);
    assign ctrl_arm   = ctrl_wr && avs_writedata[0];
    assign ctrl_clear = ctrl_wr && avs_writedata[1];
    assign ctrl_force = ctrl_wr && avs_writedata[2];
    assign data_rd    = avs_read && (avs_address == AddrData);
    assign pop        = data_rd && (state_q == StDone) && (fill_q != '0);
    assign cap_wr     = (state_q == StCapture);

    // Offset-binary to two's complement is just an MSB flip
    assign s = ADC_OFFSET_BINARY ? {~adc_q2[13], adc_q2[12:0]} : adc_q2;

    // |s| with -8192 saturated to 8191 so it fits the 13-bit threshold domain
    always_comb begin
        mag_full = s[13] ? (~s + 14'd1) : s;
        mag      = mag_full[13] ? 13'h1fff : mag_full[12:0];
    end

    assign over_thresh  = (mag > thresh_q);
    assign trig_cnt_inc = over_thresh ? (trig_cnt_q + 4'd1) : 4'd0;

    // LENGTH writes clamp to 1..DEPTH
    always_comb begin
        if (avs_writedata == 32'd0) begin
            length_wr = LW'(1);
        end else if (avs_writedata > DEPTH) begin
            length_wr = LW'(DEPTH);
        end else begin
            length_wr = avs_writedata[LW-1:0];
        end
    end

    // Two-stage ADC input registers
    always_ff @(posedge clk) begin
        if (reset) begin
            adc_q1 <= '0;
            adc_q2 <= '0;
        end else begin
            adc_q1 <= adc_data;
            adc_q2 <= adc_q1;
        end
    end

    // Capture FSM: CLEAR beats ARM, ARM beats everything else
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fill_q        <= '0;
            trig_cnt_q    <= '0;
            triggered_q   <= 1'b0;
            overflow_rd_q <= 1'b0;
        end else if (ctrl_clear) begin
            state_q       <= StIdle;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fill_q        <= '0;
            trig_cnt_q    <= '0;
            overflow_rd_q <= 1'b0;
        end else if (ctrl_arm) begin
            state_q       <= StArmed;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fill_q        <= '0;
            trig_cnt_q    <= '0;
            triggered_q   <= 1'b0;
            overflow_rd_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                end
                StArmed: begin
                    if (ctrl_force) begin
                        state_q    <= StCapture;
                        trig_cnt_q <= '0;
                    end else if (trig_cnt_inc == 4'(TRIG_HOLD)) begin
                        state_q     <= StCapture;
                        triggered_q <= 1'b1;
                        trig_cnt_q  <= '0;
                    end else begin
                        trig_cnt_q <= trig_cnt_inc;
                    end
                end
                StCapture: begin
                    wr_ptr_q <= wr_ptr_q + AW'(1);
                    fill_q   <= fill_q + LW'(1);
                    // >= guards against LENGTH being lowered mid-capture
                    if ((fill_q + LW'(1)) >= length_q) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    if (data_rd) begin
                        if (fill_q != '0) begin
                            rd_ptr_q <= rd_ptr_q + AW'(1);
                            fill_q   <= fill_q - LW'(1);
                        end else begin
                            overflow_rd_q <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // Capture RAM: write port in CAPTURE, registered read at the read pointer
    always_ff @(posedge clk) begin
        if (cap_wr) begin
            mem[wr_ptr_q] <= s;
        end
        ram_rdata_q <= mem[rd_ptr_q];
    end

    // Read/write CSRs
    always_ff @(posedge clk) begin
        if (reset) begin
            thresh_q <= 13'h0400;
            length_q <= LW'(DEPTH);
            irq_en_q <= 1'b0;
        end else if (avs_write) begin
            case (avs_address)
                AddrCtrl:   irq_en_q <= avs_writedata[8];
                AddrThresh: thresh_q <= avs_writedata[12:0];
                AddrLength: length_q <= length_wr;
                default: begin
                end
            endcase
        end
    end

    // CSR read mux; DATA is served from the RAM output register instead
    always_comb begin
        csr_rdata_d = '0;
        case (avs_address)
            AddrCtrl:   csr_rdata_d[8] = irq_en_q;
            AddrThresh: csr_rdata_d[12:0] = thresh_q;
            AddrLength: csr_rdata_d[LW-1:0] = length_q;
            AddrStatus: csr_rdata_d = {16'(fill_q), 12'd0, triggered_q, overflow_rd_q, state_q};
            default: begin
            end
        endcase
    end

    // Read data register, one cycle after avs_read
    always_ff @(posedge clk) begin
        if (reset) begin
            csr_rdata_q <= '0;
            data_sel_q  <= 1'b0;
        end else begin
            csr_rdata_q <= avs_read ? csr_rdata_d : 32'd0;
            data_sel_q  <= pop;
        end
    end

    assign avs_readdata = data_sel_q ? {{18{ram_rdata_q[13]}}, ram_rdata_q} : csr_rdata_q;

    // Level interrupt, one cycle behind the DONE state
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= (state_q == StDone) && irq_en_q;
        end
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_ofdm_adc_capture.sv
// Self-checking bench for ofdm_adc_capture: CSR vector table plus
// multi-cycle capture sequences; read data is checked through a scoreboard.

module tb_ofdm_adc_capture;

    localparam int unsigned Depth     = 1024;
    localparam bit          OffsetBin = 1'b1;
    localparam int unsigned TrigHold  = 4;

    logic        clk;
    logic        reset;
    logic [13:0] adc_data;
    logic [2:0]  avs_address;
    logic        avs_read;
    logic [31:0] avs_readdata;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        irq;

    ofdm_adc_capture #(
        .DEPTH             (Depth),
        .ADC_OFFSET_BINARY (OffsetBin),
        .TRIG_HOLD         (TrigHold)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .adc_data      (adc_data),
        .avs_address   (avs_address),
        .avs_read      (avs_read),
        .avs_readdata  (avs_readdata),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .irq           (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] exp;
        string       nm;
    } sb_t;

    typedef struct {
        logic        wr;
        logic [2:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
        string       nm;
    } vec_t;

    sb_t  sb_q[$];
    vec_t tbl[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    logic rd_v   = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [13:0] enc(input int v);
        logic [13:0] t;
        t = 14'(v);
        return OffsetBin ? (t ^ 14'h2000) : t;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        avs_write     = 1'b1;
        avs_address   = a;
        avs_writedata = d;
        @(negedge clk);
        avs_write = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] e, input string nm);
        sb_t t;
        t.exp = e;
        t.nm  = nm;
        sb_q.push_back(t);
        avs_read    = 1'b1;
        avs_address = a;
        @(negedge clk);
        avs_read = 1'b0;
    endtask

    // Scoreboard: readdata is due one cycle after each sampled avs_read
    always @(posedge clk) rd_v <= avs_read;

    always @(negedge clk) begin
        if (rd_v) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_read", 32'd1, 32'd0);
            end else begin
                sb_t t;
                t = sb_q.pop_front();
                check(t.nm, avs_readdata, t.exp);
            end
        end
    end

    function automatic vec_t mk(input logic w, input logic [2:0] a, input logic [31:0] d,
                                input logic [31:0] e, input string nm);
        vec_t v;
        v.wr   = w;
        v.addr = a;
        v.data = d;
        v.exp  = e;
        v.nm   = nm;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    int seq[$];

    initial begin
        tbl.push_back(mk(1'b0, 3'd3, 0, 32'h0000_0000, "rst_status"));
        tbl.push_back(mk(1'b0, 3'd1, 0, 32'h0000_0400, "rst_thresh"));
        tbl.push_back(mk(1'b0, 3'd2, 0, 32'd1024,      "rst_length"));
        tbl.push_back(mk(1'b0, 3'd0, 0, 32'h0000_0000, "rst_ctrl"));
        tbl.push_back(mk(1'b0, 3'd4, 0, 32'h0000_0000, "idle_data"));
        tbl.push_back(mk(1'b0, 3'd5, 0, 32'h0000_0000, "rd_addr5"));
        tbl.push_back(mk(1'b0, 3'd6, 0, 32'h0000_0000, "rd_addr6"));
        tbl.push_back(mk(1'b0, 3'd7, 0, 32'h0000_0000, "rd_addr7"));
        tbl.push_back(mk(1'b1, 3'd1, 32'hffff_ffff, 0, ""));
        tbl.push_back(mk(1'b0, 3'd1, 0, 32'h0000_1fff, "thresh_mask"));
        tbl.push_back(mk(1'b1, 3'd2, 32'd0, 0, ""));
        tbl.push_back(mk(1'b0, 3'd2, 0, 32'd1,         "len_clamp_lo"));
        tbl.push_back(mk(1'b1, 3'd2, 32'd5000, 0, ""));
        tbl.push_back(mk(1'b0, 3'd2, 0, 32'd1024,      "len_clamp_hi"));
        tbl.push_back(mk(1'b1, 3'd2, 32'd37, 0, ""));
        tbl.push_back(mk(1'b0, 3'd2, 0, 32'd37,        "len_plain"));
        tbl.push_back(mk(1'b1, 3'd5, 32'hffff_ffff, 0, ""));
        tbl.push_back(mk(1'b0, 3'd5, 0, 32'h0000_0000, "wr_addr5_ignored"));
        tbl.push_back(mk(1'b1, 3'd0, 32'h0000_0100, 0, ""));
        tbl.push_back(mk(1'b0, 3'd0, 0, 32'h0000_0100, "ctrl_irq_en"));
        tbl.push_back(mk(1'b1, 3'd0, 32'h0000_0000, 0, ""));
        tbl.push_back(mk(1'b0, 3'd0, 0, 32'h0000_0000, "ctrl_irq_dis"));
        tbl.push_back(mk(1'b0, 3'd3, 0, 32'h0000_0000, "status_still_idle"));

        reset         = 1'b1;
        adc_data      = enc(0);
        avs_address   = '0;
        avs_read      = 1'b0;
        avs_write     = 1'b0;
        avs_writedata = '0;
        idle(3);
        reset = 1'b0;
        @(negedge clk);
        check("rst_irq", {31'd0, irq}, 32'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].wr) wr(tbl[i].addr, tbl[i].data);
            else           rd(tbl[i].addr, tbl[i].exp, tbl[i].nm);
        end

        // Amplitude trigger: a 3-run must not fire, the later 4-run must
        wr(3'd1, 32'd100);
        wr(3'd2, 32'd8);
        wr(3'd0, 32'h1);
        seq = '{101, -101, 101, 50, 101, 101, -101, 101};
        for (int k = 0; k < 12; k++) seq.push_back(k * 700 - 2000);
        foreach (seq[i]) begin
            adc_data = enc(seq[i]);
            @(negedge clk);
        end
        idle(3);
        rd(3'd3, 32'h0008_000b, "trig_status");
        for (int k = 0; k < 8; k++) rd(3'd4, 32'(k * 700 - 2000), "trig_ramp");
        rd(3'd3, 32'h0000_000b, "trig_drained");
        check("trig_irq_off", {31'd0, irq}, 32'd0);

        // Offset-binary full-scale negative: -8192, magnitude saturates to 8191
        adc_data = 14'h0000;
        wr(3'd1, 32'd8190);
        wr(3'd2, 32'd1);
        wr(3'd0, 32'h1);
        idle(10);
        rd(3'd3, 32'h0001_000b, "sat_trig_status");
        rd(3'd4, 32'hffff_e000, "sat_sample");
        wr(3'd1, 32'd8191);
        wr(3'd0, 32'h1);
        idle(8);
        rd(3'd3, 32'h0000_0001, "sat_no_trig");
        wr(3'd0, 32'h4);
        idle(3);
        rd(3'd3, 32'h0001_0003, "force_status");
        rd(3'd4, 32'hffff_e000, "force_sample");

        // Reading past the end sets the sticky overflow flag
        adc_data = enc(77);
        wr(3'd2, 32'd2);
        idle(2);
        wr(3'd0, 32'h1);
        wr(3'd0, 32'h4);
        idle(4);
        rd(3'd4, 32'd77, "ovf_rd0");
        rd(3'd4, 32'd77, "ovf_rd1");
        rd(3'd4, 32'd0,  "ovf_rd2");
        rd(3'd3, 32'h0000_0007, "ovf_status");
        wr(3'd0, 32'h1);
        rd(3'd3, 32'h0000_0001, "ovf_cleared_by_arm");
        wr(3'd0, 32'h3);
        rd(3'd3, 32'h0000_0000, "clear_beats_arm");

        // Re-ARM in the middle of a capture discards what was written
        adc_data = enc(300);
        wr(3'd2, 32'd8);
        idle(2);
        wr(3'd0, 32'h1);
        wr(3'd0, 32'h4);
        idle(2);
        wr(3'd0, 32'h1);
        rd(3'd3, 32'h0000_0001, "rearm_status");
        adc_data = enc(-4321);
        idle(3);
        wr(3'd0, 32'h4);
        idle(10);
        rd(3'd3, 32'h0008_0003, "rearm_done");
        for (int k = 0; k < 8; k++) rd(3'd4, 32'(-4321), "rearm_fresh");

        // Interrupt timing with LENGTH clamped to 1
        adc_data = enc(-9);
        wr(3'd0, 32'h100);
        rd(3'd0, 32'h0000_0100, "irq_en_rd");
        wr(3'd2, 32'd0);
        rd(3'd2, 32'd1, "len0_clamp");
        idle(2);
        wr(3'd0, 32'h101);
        wr(3'd0, 32'h104);
        idle(1);
        check("irq_lag", {31'd0, irq}, 32'd0);
        idle(1);
        check("irq_high", {31'd0, irq}, 32'd1);
        rd(3'd3, 32'h0001_0003, "irq_status");
        rd(3'd4, 32'(-9), "irq_sample");
        wr(3'd0, 32'h102);
        idle(1);
        check("irq_low", {31'd0, irq}, 32'd0);
        rd(3'd3, 32'h0000_0000, "clear_status");

        idle(3);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
